// File: rtl/serial_catch_seq_pkg.sv
// Shared definitions for the bit-serial catch sequencer and its 1-to-9 demux.
package serial_catch_seq_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Number of consecutive frame bits captured by the demux.
   localparam int CATCH_LEN = 9;

endpackage

// File: rtl/serial_catch_idx.sv
// Bit-index counter for serial_catch_seq: clear, load-1 (sof), increment with
// wrap to 0 after the last frame index.
module serial_catch_idx #(
   parameter int FRAME_LEN = 32,
   parameter int SEL_W     = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             load1,
   input  logic             inc,
   output logic [SEL_W-1:0] idx
);

   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(FRAME_LEN - 1);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         idx <= '0;
      end else if (load1) begin
         idx <= SEL_W'(1);
      end else if (inc) begin
         idx <= (idx == LAST_IDX) ? '0 : idx + SEL_W'(1);
      end
   end

endmodule

// File: rtl/serial_catch_seq.sv
// Sequencer steering a framed serial bitstream into a 1-to-9 catch demux.
// Optional SERIAL_CATCH_STATS_EN adds saturating frame/error counters.
module serial_catch_seq
   import serial_catch_seq_pkg::*;
#(
   parameter int FRAME_LEN       = 32,
   parameter int CATCH_START_BIT = 10,
   parameter int SEL_W           = 5,
   parameter int PARK_SEL        = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             abort,
   input  logic             ser_valid,
   input  logic             ser_sof,
   output logic             ser_ready,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic [SEL_W-1:0] bit_idx,
   output logic             frame_valid,
   output logic             err_sof,
   output logic             err_nosof
`ifdef SERIAL_CATCH_STATS_EN
   ,
   input  logic             stats_clr,
   output logic [15:0]      frame_cnt,
   output logic [15:0]      err_cnt
`endif
);

   localparam logic [SEL_W-1:0] PARK       = SEL_W'(PARK_SEL);
   localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(FRAME_LEN - 1);
   localparam logic [SEL_W-1:0] CATCH_LAST = SEL_W'(CATCH_START_BIT + CATCH_LEN - 1);

   state_t state, state_nx;
   logic   acc;
   logic   idx_clr, idx_load1, idx_inc;
   logic   fv_nx, esof_nx, enosof_nx;

   assign ser_ready = enable && !abort;
   assign acc       = ser_valid && ser_ready;
   assign busy      = (state == RUN);

   serial_catch_idx #(
      .FRAME_LEN (FRAME_LEN),
      .SEL_W     (SEL_W)
   ) u_idx (
      .clk   (clk),
      .reset (reset),
      .clr   (idx_clr),
      .load1 (idx_load1),
      .inc   (idx_inc),
      .idx   (bit_idx)
   );

   // The demux samples every clock, so sel parks whenever no bit is counted.
   always_comb begin
      state_nx  = state;
      sel       = PARK;
      idx_clr   = 1'b0;
      idx_load1 = 1'b0;
      idx_inc   = 1'b0;
      fv_nx     = 1'b0;
      esof_nx   = 1'b0;
      enosof_nx = 1'b0;
      if (abort) begin
         state_nx = IDLE;
         idx_clr  = 1'b1;
      end else if (acc) begin
         if (ser_sof) begin
            sel       = '0;
            idx_load1 = 1'b1;
            state_nx  = RUN;
            esof_nx   = (state == RUN);
         end else if (state == IDLE) begin
            enosof_nx = 1'b1;
         end else begin
            sel     = bit_idx;
            idx_inc = 1'b1;
            fv_nx   = (bit_idx == CATCH_LAST);
            if (bit_idx == LAST_IDX) begin
               state_nx = IDLE;
            end
         end
      end
   end

   // Pulses register alongside the demux outputs they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         frame_valid <= 1'b0;
         err_sof     <= 1'b0;
         err_nosof   <= 1'b0;
      end else begin
         state       <= state_nx;
         frame_valid <= fv_nx;
         err_sof     <= esof_nx;
         err_nosof   <= enosof_nx;
      end
   end

`ifdef SERIAL_CATCH_STATS_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset || stats_clr) begin
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         if (frame_valid) begin
            frame_cnt <= sat_inc16(frame_cnt);
         end
         if (err_sof || err_nosof) begin
            err_cnt <= sat_inc16(err_cnt);
         end
      end
   end
`endif

endmodule

// File: tb/tb_serial_catch_seq.sv
// Self-checking bench for serial_catch_seq with a behavioural 1-to-9 demux.
// Covers SERIAL_CATCH_STATS_EN counters when that macro is defined.
module tb_serial_catch_seq;
   import serial_catch_seq_pkg::*;

   localparam int FL   = 32;
   localparam int CSB  = 10;
   localparam int SW   = 5;
   localparam int PARK = 18;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          abort = 1'b0;
   logic          ser_valid = 1'b0;
   logic          ser_sof = 1'b0;
   logic          data_in = 1'b0;
   logic          ser_ready, busy, frame_valid, err_sof, err_nosof;
   logic [SW-1:0] sel, bit_idx;
`ifdef SERIAL_CATCH_STATS_EN
   logic          stats_clr = 1'b0;
   logic [15:0]   frame_cnt, err_cnt;
`endif

   serial_catch_seq #(
      .FRAME_LEN       (FL),
      .CATCH_START_BIT (CSB),
      .SEL_W           (SW),
      .PARK_SEL        (PARK)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .abort       (abort),
      .ser_valid   (ser_valid),
      .ser_sof     (ser_sof),
      .ser_ready   (ser_ready),
      .sel         (sel),
      .busy        (busy),
      .bit_idx     (bit_idx),
      .frame_valid (frame_valid),
      .err_sof     (err_sof),
      .err_nosof   (err_nosof)
`ifdef SERIAL_CATCH_STATS_EN
      ,
      .stats_clr   (stats_clr),
      .frame_cnt   (frame_cnt),
      .err_cnt     (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural demux: output k latches data_in whenever sel == CSB+k.
   logic [8:0] dmx = '0;
   always @(posedge clk) begin
      if (int'(sel) >= CSB && int'(sel) <= CSB + 8) dmx[int'(sel) - CSB] <= data_in;
   end

   int fv_seen = 0;
   always @(posedge clk) if (frame_valid) fv_seen++;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference model state and scoreboard.
   typedef struct packed {
      logic       fv;
      logic       esof;
      logic       enosof;
      logic       busy;
      logic [4:0] idx;
      logic [8:0] catch_bits;
   } exp_t;

   exp_t sbq[$];
   bit   m_run = 0;
   int   m_idx = 0;
   logic fbits[0:FL-1];

   task automatic cyc(input logic en, input logic ab, input logic v, input logic sof, input logic d);
      exp_t       e;
      exp_t       got;
      logic       rdy;
      logic       acc;
      logic [4:0] esel;
      @(negedge clk);
      enable = en; abort = ab; ser_valid = v; ser_sof = sof; data_in = d;
      e    = '0;
      rdy  = en && !ab;
      acc  = v && rdy;
      esel = 5'(PARK);
      if (ab) begin
         m_run = 0; m_idx = 0;
      end else if (acc) begin
         if (sof) begin
            e.esof = m_run;
            esel = '0; m_run = 1; m_idx = 1; fbits[0] = d;
         end else if (!m_run) begin
            e.enosof = 1'b1;
         end else begin
            esel = 5'(m_idx);
            fbits[m_idx] = d;
            if (m_idx == CSB + 8) begin
               e.fv = 1'b1;
               for (int k = 0; k < 9; k++) e.catch_bits[k] = fbits[CSB + k];
            end
            if (m_idx == FL - 1) begin
               m_run = 0; m_idx = 0;
            end else begin
               m_idx++;
            end
         end
      end
      e.busy = m_run;
      e.idx  = 5'(m_idx);
      sbq.push_back(e);
      #1;
      chk("ser_ready", ser_ready, rdy);
      chk("sel", sel, esel);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
      end else begin
         got = sbq.pop_front();
         chk("frame_valid", frame_valid, got.fv);
         chk("err_sof", err_sof, got.esof);
         chk("err_nosof", err_nosof, got.enosof);
         chk("busy", busy, got.busy);
         chk("bit_idx", bit_idx, got.idx);
         if (got.fv) chk("catch", dmx, got.catch_bits);
      end
   endtask

   // mode 0: bit i = i[0]; mode 1: random bits.
   task automatic send_range(input int lo, input int hi, input int mode);
      for (int i = lo; i <= hi; i++)
         cyc(1'b1, 1'b0, 1'b1, (i == 0), (mode == 0) ? 1'(i) : 1'($urandom_range(0, 1)));
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; ser_valid = 1'b0; abort = 1'b0; enable = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_bit_idx", bit_idx, 0);
      chk("rst_frame_valid", frame_valid, 0);
      chk("rst_err_sof", err_sof, 0);
      chk("rst_err_nosof", err_nosof, 0);
      chk("rst_sel", sel, PARK);
      @(negedge clk);
      reset = 1'b0;
      m_run = 0; m_idx = 0;
   endtask

   typedef struct packed {
      logic       en, ab, v, sof;
      logic       rdy;
      logic [4:0] sel;
      logic       busy;
      logic [4:0] idx;
      logic       nosof;
   } tv_t;

   tv_t tbl[9];
   int  fv0;

   initial begin
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd18, 1'b0, 5'd0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd18, 1'b0, 5'd0, 1'b1};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd18, 1'b0, 5'd0, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd18, 1'b0, 5'd0, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0,  1'b1, 5'd1, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1,  1'b1, 5'd2, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd18, 1'b1, 5'd2, 1'b0};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd18, 1'b0, 5'd0, 1'b0};
      tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd18, 1'b0, 5'd0, 1'b1};

      do_reset();

      // Short control vectors starting from IDLE.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         enable = tbl[i].en; abort = tbl[i].ab; ser_valid = tbl[i].v; ser_sof = tbl[i].sof;
         #1;
         chk($sformatf("tv%0d_ready", i), ser_ready, tbl[i].rdy);
         chk($sformatf("tv%0d_sel", i), sel, tbl[i].sel);
         @(posedge clk);
         #1;
         chk($sformatf("tv%0d_busy", i), busy, tbl[i].busy);
         chk($sformatf("tv%0d_idx", i), bit_idx, tbl[i].idx);
         chk($sformatf("tv%0d_nosof", i), err_nosof, tbl[i].nosof);
      end
      do_reset();

      // Contiguous frame, bit i = i[0].
      fv0 = fv_seen;
      send_range(0, 31, 0);
      chk("contig_fv_count", fv_seen - fv0, 1);
      chk("contig_catch", dmx, 9'b010101010);
      chk("contig_idle", busy, 0);

      // Gapped frame: stalls before indices 12 and 18 with junk on data_in.
      fv0 = fv_seen;
      send_range(0, 11, 1);
      gap(3);
      send_range(12, 17, 1);
      gap(3);
      send_range(18, 31, 1);
      chk("gap_fv_count", fv_seen - fv0, 1);

      // Resync at index 15.
      fv0 = fv_seen;
      send_range(0, 14, 1);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("resync_fv_none", fv_seen - fv0, 0);
      send_range(1, 31, 1);
      chk("resync_fv_count", fv_seen - fv0, 1);

      // Abort with a simultaneous valid bit at index 14, then a stray bit.
      fv0 = fv_seen;
      send_range(0, 13, 1);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("abort_fv_none", fv_seen - fv0, 0);

      // Enable stall at index 17, then reset at index 16 of the next frame.
      fv0 = fv_seen;
      send_range(0, 16, 1);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      send_range(17, 31, 1);
      chk("stall_fv_count", fv_seen - fv0, 1);
      fv0 = fv_seen;
      send_range(0, 15, 1);
      do_reset();
      gap(4);
      chk("reset_fv_none", fv_seen - fv0, 0);

`ifdef SERIAL_CATCH_STATS_EN
      do_reset();
      chk("stats_rst_frame", frame_cnt, 0);
      chk("stats_rst_err", err_cnt, 0);
      for (int f = 0; f < 3; f++) send_range(0, 31, 1);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      gap(1);
      chk("stats_frame_cnt", frame_cnt, 3);
      chk("stats_err_cnt", err_cnt, 2);
      send_range(0, 18, 1);
      chk("stats_clr_on_fv", frame_valid, 1);
      stats_clr = 1'b1;
      send_range(19, 19, 1);
      stats_clr = 1'b0;
      chk("stats_clr_frame", frame_cnt, 0);
      chk("stats_clr_err", err_cnt, 0);
      send_range(20, 31, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_catch_seq.md
Name: serial_catch_seq

Overview:
- Sequencer for the 1-to-9 bit-serial catch demux.
- Accepts a framed serial bitstream through a valid/ready handshake and tracks the bit index within each frame.
- Drives the demux select so that exactly frame bits CATCH_START_BIT..CATCH_START_BIT+8 land in demux outputs 0..8.
- Pulses frame_valid in the cycle the demux outputs hold a complete, coherent 9-bit catch.

Parameters:
- FRAME_LEN, 32: bits per frame, range 10..32; indices run 0..FRAME_LEN-1.
- CATCH_START_BIT, 10: first caught index; must match the demux instance; CATCH_START_BIT+8 <= FRAME_LEN-1.
- SEL_W, 5: select width; 2**SEL_W >= FRAME_LEN.
- PARK_SEL, 0: select driven when no bit is accepted; must lie outside CATCH_START_BIT..CATCH_START_BIT+7.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  when 0, stall the stream (ser_ready=0); frame position is retained
- abort  in  1  single-cycle pulse: drop the current frame
- ser_valid  in  1  serial bit present on the demux Data_in this cycle
- ser_sof  in  1  qualifies the current bit as frame index 0
- ser_ready  out  1  enable && !abort (combinational)
- sel  out  SEL_W  to the demux sel; combinational
- busy  out  1  state==RUN
- bit_idx  out  SEL_W  index of the next expected bit (registered)
- frame_valid  out  1  one-cycle pulse; demux outputs 0..8 are valid this cycle
- err_sof  out  1  one-cycle pulse: sof seen mid-frame (resync)
- err_nosof  out  1  one-cycle pulse: bit accepted in IDLE without sof (dropped)

Behaviour:
- acc = ser_valid && ser_ready.
- sel = bit index of the accepted bit when acc and the bit is counted; otherwise PARK_SEL.
  - The demux samples every clock, so non-accept cycles must park.
  - A park only clobbers demux out_8, which is rewritten by the index CATCH_START_BIT+8 bit.
- States:
  - IDLE: reset state.
    - acc && sof: sel=0, bit_idx<=1, go RUN.
    - acc && !sof: sel=PARK_SEL, err_nosof<=1, stay in IDLE.
  - RUN, acc && !sof: sel=bit_idx, bit_idx<=bit_idx+1.
    - If bit_idx==FRAME_LEN-1: bit_idx<=0, go IDLE (frame end).
  - RUN, acc && sof: resync.
    - sel=0, bit_idx<=1, err_sof<=1.
    - No frame_valid from the abandoned frame.
  - RUN, !acc: hold bit_idx, sel=PARK_SEL.
- frame_valid (registered) is set at the edge ending the accept cycle whose sel==CATCH_START_BIT+8.
  - It is therefore aligned with the demux registered outputs: 1 cycle after that bit is accepted.
  - Pulse only; there is no backpressure on the caught bits, and downstream must sample in that cycle.
- abort: ser_ready=0 and sel=PARK_SEL that cycle; next state IDLE, bit_idx<=0; a simultaneous ser_valid is not accepted.
- enable=0 mid-frame: stall only; the catch completes once the stream resumes.
- reset, including mid-frame: state IDLE, bit_idx=0, frame_valid=err_sof=err_nosof=0.
  - Combinational outputs follow: sel=PARK_SEL, busy=0.
  - Any partial catch is discarded (no frame_valid).
- All pulse outputs default to 0 each cycle.

Optional Feature:
- Macro SERIAL_CATCH_STATS_EN.
- Defined: adds outputs frame_cnt[15:0] (frame_valid pulses) and err_cnt[15:0] (err_sof + err_nosof events; +1 per cycle if either fires).
  - Both counters saturate at 16'hFFFF.
  - Both clear on reset or on input stats_clr (1 bit); clear wins over a simultaneous increment.
- Undefined: stats_clr, frame_cnt and err_cnt are absent; no counter logic.

Decomposition:
- Shared package: state enum (IDLE, RUN) and a localparam CATCH_LEN=9.
  - The demux uses the same constant.
- One sub-module is natural: serial_catch_idx, the bit-index counter with load-1/clear/increment/wrap.
- The FSM, sel mux and pulse generation stay in the top.

Test Plan:
- Contiguous frame: sof+32 valid bits with bit i = i[0] -> sel steps 0..31; frame_valid exactly once, the cycle after the index-18 accept; demux outputs = 0,1,0,1,0,1,0,1,0; busy drops after index 31.
- Gapped frame: ser_valid low 3 cycles at indices 12 and 18 -> sel=PARK_SEL in gaps; demux outputs still correct; frame_valid one cycle after index 18 is accepted.
- Resync: sof reasserted at index 15 -> err_sof pulse; bit_idx=1 next; no frame_valid until new index 18.
- Abort with simultaneous ser_valid at index 14 -> ser_ready=0, bit not consumed; IDLE; no frame_valid; next non-sof bit -> err_nosof.
- enable=0 for 5 cycles at index 17, plus reset at index 16 of a second frame -> first frame completes normally; reset yields IDLE, sel=PARK_SEL, bit_idx=0, no frame_valid.
- STATS_EN: 3 good frames + 2 errors, then stats_clr coincident with a frame_valid -> frame_cnt=3, err_cnt=2, then both 0.
